// File: rtl/collatz_sweep_ctrl.sv
// collatz_sweep_ctrl
//   Sequencer for one Collatz step-count core. Sweeps N over [n_first, n_last],
//   launching the core once per point, capturing its step count and clearing it
//   between points. Reports the largest step count seen and the N that produced it.
//
//   Optional feature macro: SWEEP_WDOG_EN
//     defined   : per-point watchdog; a point whose core run reaches TIMEOUT cycles
//                 is skipped and the sticky err flag is set.
//     undefined : LAUNCH/RUN wait indefinitely; err is tied 0.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 begin sweep (sampled only in IDLE)
//   n_first, n_last       sweep range, inclusive; latched on accepted start
//   busy                  sweep in progress (LAUNCH/RUN/CAPTURE/CLEAR)
//   done                  one-cycle pulse at end of sweep
//   cur_n                 N currently being evaluated
//   max_steps, max_n      best step count so far and the N that produced it
//   err                   sticky watchdog flag
//   core_go               run request to core, high through LAUNCH and RUN
//   core_clr              one-cycle clear to core (CLEAR state)
//   core_n                operand to core (equals cur_n)
//   core_busy, core_steps core status; core_steps valid when core_busy falls
module collatz_sweep_ctrl #(
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] n_first,
  input  logic [W-1:0] n_last,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] cur_n,
  output logic [W-1:0] max_steps,
  output logic [W-1:0] max_n,
  output logic         err,
  output logic         core_go,
  output logic         core_clr,
  output logic [W-1:0] core_n,
  input  logic         core_busy,
  input  logic [W-1:0] core_steps
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_CAPTURE,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t       state;
  logic [W-1:0] n_last_q;

`ifdef SWEEP_WDOG_EN
  logic [W-1:0] wd_cnt;
  logic         err_q;
  logic         wd_hit;

  assign wd_hit = (wd_cnt == W'(TIMEOUT));
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

  assign core_go  = (state == S_LAUNCH) || (state == S_RUN);
  assign core_clr = (state == S_CLEAR);
  assign done     = (state == S_DONE);
  assign core_n   = cur_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      n_last_q  <= '0;
      busy      <= 1'b0;
      cur_n     <= '0;
      max_steps <= '0;
      max_n     <= '0;
`ifdef SWEEP_WDOG_EN
      wd_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            max_steps <= '0;
            max_n     <= '0;
            if ((n_first != '0) && (n_first <= n_last)) begin
              n_last_q <= n_last;
              cur_n    <= n_first;
              busy     <= 1'b1;
              state    <= S_LAUNCH;
`ifdef SWEEP_WDOG_EN
              err_q    <= 1'b0;
              wd_cnt   <= '0;
`endif
            end else begin
              state <= S_DONE;
            end
          end
        end

        S_LAUNCH: begin
`ifdef SWEEP_WDOG_EN
          if (wd_hit) begin
            err_q <= 1'b1;
            state <= S_CLEAR;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (core_busy) state <= S_RUN;
          end
`else
          if (core_busy) state <= S_RUN;
`endif
        end

        S_RUN: begin
`ifdef SWEEP_WDOG_EN
          if (wd_hit) begin
            err_q <= 1'b1;
            state <= S_CLEAR;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (!core_busy) state <= S_CAPTURE;
          end
`else
          if (!core_busy) state <= S_CAPTURE;
`endif
        end

        S_CAPTURE: begin
          // Strict compare: on a tie the earlier (smaller) N is kept.
          if (core_steps > max_steps) begin
            max_steps <= core_steps;
            max_n     <= cur_n;
          end
          state <= S_CLEAR;
        end

        S_CLEAR: begin
          // Compare before incrementing so n_last = all-ones ends without wrapping.
          if (cur_n == n_last_q) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            cur_n <= cur_n + 1'b1;
            state <= S_LAUNCH;
`ifdef SWEEP_WDOG_EN
            wd_cnt <= '0;
`endif
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
